// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Width of a source tag able to name n producers (never narrower than 1 bit).
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping modulo NUM_REQ. Works for non-power-of-2 request counts.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  localparam logic [ID_WIDTH:0] NUM_REQ_C = (ID_WIDTH+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [ID_WIDTH-1:0]  offset;
  logic [ID_WIDTH:0]    sum;

  // Rotate the request vector so rr_ptr lands at bit 0, find the first set bit,
  // then add the rotation back modulo NUM_REQ.
  always_comb begin
    doubled = {req, req} >> rr_ptr;
    rotated = doubled[NUM_REQ-1:0];
    found   = 1'b0;
    offset  = {ID_WIDTH{1'b0}};
    // Scan downwards so the lowest set position is the one that sticks.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        offset = ID_WIDTH'(k);
      end else begin
        found  = found;
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= NUM_REQ_C) begin
      idx = ID_WIDTH'(sum - NUM_REQ_C);
    end else begin
      idx = sum[ID_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-side arbiter sharing one sync_fifo among NUM_REQ producers.
// A grant is held for a whole packet (bounded by MAX_BURST); beats are tagged
// with the source ID and forwarded with zero latency, honouring fifo_full.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
  output logic                           fifo_write_en,
  input  logic                           fifo_full,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t          state;
  logic [ID_WIDTH-1:0] owner;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [CNT_W-1:0]    beat_cnt;

  logic                  found;
  logic [ID_WIDTH-1:0]   win_idx;
  logic [ID_WIDTH-1:0]   src;
  logic                  src_valid;
  logic                  src_last;
  logic [DATA_WIDTH-1:0] src_data;
  logic [CNT_W-1:0]      beat_cnt_inc;
  logic                  xfer;
  logic                  ends_pkt;

  // Next round-robin position after v, wrapping at NUM_REQ-1 even when
  // NUM_REQ is not a power of 2.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
    if (v == ID_WIDTH'(NUM_REQ - 1)) begin
      return {ID_WIDTH{1'b0}};
    end else begin
      return v + ID_WIDTH'(1);
    end
  endfunction

  rr_priority_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (found),
    .idx    (win_idx)
  );

  // Select the serving source: the locked owner, or the picker's winner when idle.
  always_comb begin
    if (state == ARB_LOCKED) begin
      src       = owner;
      src_valid = req_valid[owner];
    end else begin
      src       = win_idx;
      src_valid = found;
    end
    src_last = req_last[src];
  end

  // Payload mux for the selected source.
  always_comb begin
    src_data = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == src) begin
        src_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        src_data = src_data;
      end
    end
  end

  // Transfer qualification and end-of-grant detection for the current beat.
  always_comb begin
    beat_cnt_inc = beat_cnt + CNT_W'(1);
    xfer         = src_valid && !fifo_full && reset;
    if (state == ARB_LOCKED) begin
      ends_pkt = src_last || (beat_cnt_inc == MAX_BURST_C);
    end else begin
      ends_pkt = src_last || (MAX_BURST_C == CNT_W'(1));
    end
  end

  // Arbitration state machine: lock on multi-beat packets, release on last
  // beat or burst limit, and advance the round-robin pointer on release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ARB_IDLE;
      owner    <= {ID_WIDTH{1'b0}};
      rr_ptr   <= {ID_WIDTH{1'b0}};
      beat_cnt <= {CNT_W{1'b0}};
    end else if (xfer) begin
      case (state)
        ARB_IDLE: begin
          if (ends_pkt) begin
            rr_ptr <= wrap_inc(src);
          end else begin
            state    <= ARB_LOCKED;
            owner    <= src;
            beat_cnt <= CNT_W'(1);
          end
        end
        ARB_LOCKED: begin
          if (ends_pkt) begin
            state    <= ARB_IDLE;
            rr_ptr   <= wrap_inc(owner);
            beat_cnt <= {CNT_W{1'b0}};
          end else begin
            beat_cnt <= beat_cnt_inc;
          end
        end
        default: begin
          state    <= ARB_IDLE;
          beat_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output drive; everything is forced to zero while reset is asserted.
  always_comb begin
    fifo_write_en = xfer;
    busy          = (state == ARB_LOCKED);
    if (xfer) begin
      req_ready = ONE_HOT_0 << src;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
    if (!reset) begin
      fifo_din = {(ID_WIDTH+DATA_WIDTH){1'b0}};
      grant_id = {ID_WIDTH{1'b0}};
    end else begin
      fifo_din = {src, src_data};
      if (state == ARB_LOCKED) begin
        grant_id = owner;
      end else if (found) begin
        grant_id = win_idx;
      end else begin
        grant_id = {ID_WIDTH{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (4-producer instance
// plus a 3-producer instance for the non-power-of-2 wrap).
module tb_fifo_write_arbiter;

  logic         clock;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic [33:0]  fifo_din;
  logic         fifo_write_en;
  logic         fifo_full;
  logic [1:0]   grant_id;
  logic         busy;

  logic [2:0]   v3;
  logic [23:0]  d3;
  logic [2:0]   l3;
  logic [2:0]   r3;
  logic [9:0]   din3;
  logic         we3;
  logic         full3;
  logic [1:0]   gid3;
  logic         busy3;

  int checks;
  int errors;

  // Producer model: remaining beats, beats already sent, whether last is flagged.
  int rem [4];
  int sent[4];
  bit use_last[4];

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(8)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_din(fifo_din),
    .fifo_write_en(fifo_write_en), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy)
  );

  fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(8)) dut3 (
    .clock(clock), .reset(reset), .req_valid(v3), .req_data(d3),
    .req_last(l3), .req_ready(r3), .fifo_din(din3),
    .fifo_write_en(we3), .fifo_full(full3),
    .grant_id(gid3), .busy(busy3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      sent[i] = 0;
      use_last[i] = 1'b0;
    end
  endtask

  task automatic drive_model();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (rem[i] > 0);
      req_data[i*32 +: 32] = 32'(i * 256 + sent[i]);
      req_last[i] = use_last[i] && (rem[i] == 1);
    end
  endtask

  task automatic update_model(input logic [3:0] rdy);
    for (int i = 0; i < 4; i++) begin
      if (rdy[i]) begin
        rem[i]--;
        sent[i]++;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    fifo_full = 1'b0;
    clear_model();
    drive_model();
    v3 = 3'b000;
    l3 = 3'b000;
    d3 = 24'h0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fifo_full = 1'b0;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    req_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    v3 = 3'b000; l3 = 3'b000; d3 = 24'h0; full3 = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", fifo_write_en); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %0b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    checks++; if (fifo_din !== 34'h0) begin errors++; $display("FAIL reset_din: got %0h expected 0", fifo_din); end
  endtask

  task automatic test_single_beat();
    logic [3:0] rdy;
    apply_reset();
    rem[1] = 1; use_last[1] = 1'b1;
    rem[3] = 1; use_last[3] = 1'b1;
    drive_model(); #2;
    checks++; if (fifo_write_en !== 1'b1) begin errors++; $display("FAIL single_we0: got %0b expected 1", fifo_write_en); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready0: got %0b expected 0010", req_ready); end
    checks++; if (fifo_din !== {2'd1, 32'h0000_0100}) begin errors++; $display("FAIL single_din0: got %0h expected %0h", fifo_din, {2'd1, 32'h0000_0100}); end
    rdy = req_ready; step(); update_model(rdy);
    drive_model(); #2;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL single_ready1: got %0b expected 1000", req_ready); end
    checks++; if (fifo_din !== {2'd3, 32'h0000_0300}) begin errors++; $display("FAIL single_din1: got %0h expected %0h", fifo_din, {2'd3, 32'h0000_0300}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %0b expected 0", busy); end
    rdy = req_ready; step(); update_model(rdy);
    drive_model(); #2;
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL single_idle_we: got %0b expected 0", fifo_write_en); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL single_rr_ptr: got %0d expected 0", dut.rr_ptr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %0b expected 0", busy); end
    step();
  endtask

  task automatic test_burst();
    logic [3:0]  rdy;
    logic [33:0] exp_din;
    int exp_tag[6]  = '{0, 0, 0, 2, 2, 2};
    int exp_idx[6]  = '{0, 1, 2, 0, 1, 2};
    bit exp_busy[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    apply_reset();
    rem[0] = 3; use_last[0] = 1'b1;
    rem[2] = 3; use_last[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_model(); #2;
      exp_din = {2'(exp_tag[k]), 32'(exp_tag[k] * 256 + exp_idx[k])};
      checks++; if (fifo_write_en !== 1'b1) begin errors++; $display("FAIL burst_we[%0d]: got %0b expected 1", k, fifo_write_en); end
      checks++; if (fifo_din !== exp_din) begin errors++; $display("FAIL burst_din[%0d]: got %0h expected %0h", k, fifo_din, exp_din); end
      checks++; if (busy !== exp_busy[k]) begin errors++; $display("FAIL burst_busy[%0d]: got %0b expected %0b", k, busy, exp_busy[k]); end
      rdy = req_ready; step(); update_model(rdy);
    end
    drive_model(); #2;
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL burst_idle_we: got %0b expected 0", fifo_write_en); end
    step(); step();
    checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL burst_rr_hold: got %0d expected 3", dut.rr_ptr); end
  endtask

  task automatic test_forced_release();
    logic [3:0]  rdy;
    logic [33:0] exp_din;
    int exp_tag[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 1};
    int exp_idx[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 8, 9};
    apply_reset();
    rem[1] = 10; use_last[1] = 1'b0;
    rem[2] = 1;  use_last[2] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drive_model(); #2;
      exp_din = {2'(exp_tag[k]), 32'(exp_tag[k] * 256 + exp_idx[k])};
      checks++; if (fifo_write_en !== 1'b1) begin errors++; $display("FAIL forced_we[%0d]: got %0b expected 1", k, fifo_write_en); end
      checks++; if (fifo_din !== exp_din) begin errors++; $display("FAIL forced_din[%0d]: got %0h expected %0h", k, fifo_din, exp_din); end
      rdy = req_ready; step(); update_model(rdy);
    end
    // Owner has gone quiet mid-packet: the lock must hold with no timeout.
    for (int k = 0; k < 3; k++) begin
      drive_model();
      req_valid[0] = 1'b1;
      #2;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy[%0d]: got %0b expected 1", k, busy); end
      checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL hold_grant[%0d]: got %0d expected 1", k, grant_id); end
      checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL hold_we[%0d]: got %0b expected 0", k, fifo_write_en); end
      step();
    end
  endtask

  task automatic test_full_stall();
    logic [3:0]  rdy;
    logic [33:0] exp_din;
    int k;
    apply_reset();
    rem[0] = 5; use_last[0] = 1'b1;
    k = 0;
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 2) && (c <= 5);
      drive_model(); #2;
      if (fifo_full) begin
        checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL stall_we[%0d]: got %0b expected 0", c, fifo_write_en); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %0b expected 0000", c, req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %0b expected 1", c, busy); end
      end else begin
        exp_din = {2'd0, 32'(k)};
        checks++; if (fifo_write_en !== 1'b1) begin errors++; $display("FAIL stall_beat_we[%0d]: got %0b expected 1", c, fifo_write_en); end
        checks++; if (fifo_din !== exp_din) begin errors++; $display("FAIL stall_beat_din[%0d]: got %0h expected %0h", c, fifo_din, exp_din); end
        k++;
      end
      rdy = req_ready; step(); update_model(rdy);
    end
    fifo_full = 1'b0;
    drive_model(); #2;
    checks++; if (sent[0] !== 5) begin errors++; $display("FAIL stall_count: got %0d expected 5", sent[0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_release: got %0b expected 0", busy); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] rdy;
    apply_reset();
    rem[2] = 6; use_last[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_model(); #2;
      rdy = req_ready; step(); update_model(rdy);
    end
    drive_model(); #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_locked: got %0b expected 1", busy); end
    checks++; if (fifo_write_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_we: got %0b expected 1", fifo_write_en); end
    reset = 1'b0;
    #1;
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL midrst_we: got %0b expected 0", fifo_write_en); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready: got %0b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
    clear_model();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 1;
      use_last[i] = 1'b1;
    end
    drive_model();
    step();
    reset = 1'b1;
    #2;
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL postrst_grant: got %0d expected 0", grant_id); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL postrst_ready: got %0b expected 0001", req_ready); end
    step();
  endtask

  task automatic test_wrap3();
    logic [9:0] exp_din;
    apply_reset();
    v3 = 3'b111;
    l3 = 3'b111;
    d3 = {8'h22, 8'h11, 8'h00};
    for (int k = 0; k < 6; k++) begin
      #2;
      exp_din = {2'(k % 3), 8'((k % 3) * 17)};
      checks++; if (gid3 !== 2'(k % 3)) begin errors++; $display("FAIL wrap3_grant[%0d]: got %0d expected %0d", k, gid3, k % 3); end
      checks++; if (r3 !== 3'(1 << (k % 3))) begin errors++; $display("FAIL wrap3_ready[%0d]: got %0b expected %0b", k, r3, 3'(1 << (k % 3))); end
      checks++; if (din3 !== exp_din) begin errors++; $display("FAIL wrap3_din[%0d]: got %0h expected %0h", k, din3, exp_din); end
      step();
    end
    v3 = 3'b000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    full3 = 1'b0;
    test_reset();
    test_single_beat();
    test_burst();
    test_forced_release();
    test_full_stall();
    test_reset_mid_burst();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
